spike_event_core: RTL

- Parametrised successor of the TTFS spike-time store.
- Holds one TIME_W-bit firing time per input neuron in a single-port, lane-packed memory.
- The memory is reachable from an OBI-style slave port and from a record port driven by the AER output side.
- On every tick it scans the memory and pushes the address of each neuron due to fire into an internal output FIFO, which the downstream AER-in sequencer drains.
- Adds several features over the previous generation: generic width/depth, per-lane byte-enabled writes, a selectable fire-once threshold mode, and FIFO back-pressure stalling of the scan.

---
 rtl/spike_event_core_if.sv | 33 +++
 rtl/spike_event_core.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/spike_event_core_if.sv
// spike_event_core_if
// Purpose: OBI-style slave bus bundle for the spike-time store.
// Signals:
//   bus_req_i    request (master -> slave)
//   bus_we_i     write enable (master -> slave)
//   bus_be_i     byte enables, BUS_W/8 bits (master -> slave)
//   bus_addr_i   32-bit byte address (master -> slave)
//   bus_wdata_i  write data (master -> slave)
//   bus_gnt_o    grant (slave -> master)
//   bus_rvalid_o response valid, one cycle after grant (slave -> master)
//   bus_rdata_o  read data, zero for write responses (slave -> master)
interface spike_event_core_if #(
  parameter int BUS_W = 32
);
  logic               bus_req_i;
  logic               bus_we_i;
  logic [BUS_W/8-1:0] bus_be_i;
  logic [31:0]        bus_addr_i;
  logic [BUS_W-1:0]   bus_wdata_i;
  logic               bus_gnt_o;
  logic               bus_rvalid_o;
  logic [BUS_W-1:0]   bus_rdata_o;

  modport master (
    output bus_req_i, bus_we_i, bus_be_i, bus_addr_i, bus_wdata_i,
    input  bus_gnt_o, bus_rvalid_o, bus_rdata_o
  );

  modport slave (
    input  bus_req_i, bus_we_i, bus_be_i, bus_addr_i, bus_wdata_i,
    output bus_gnt_o, bus_rvalid_o, bus_rdata_o
  );
endinterface

// File: rtl/spike_event_core.sv
// spike_event_core
// Purpose: stores one TIME_W-bit firing time per neuron in a lane-packed
//   single-port memory and, on each tick request, scans it and queues the
//   address of every neuron due to fire into an output FIFO.
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   bus               OBI-style slave port (spike_event_core_if.slave)
//   start_i           begin a run: clear fired mask and overrun, then scan
//   next_tick_i       scan for the current tick_i
//   tick_i            current time tick
//   rec_valid_i/rec_addr_i/rec_ready_o  output-spike record write port
//   fifo_rd_i         pop output FIFO
//   fifo_data_o       head neuron address (valid while not empty)
//   fifo_empty_o      output FIFO empty
//   busy_o            scan in progress
//   done_o            one-cycle pulse at scan completion
//   overrun_o         sticky: tick request arrived while busy
module spike_event_core #(
  parameter int N          = 256,
  parameter int TIME_W     = 8,
  parameter int BUS_W      = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int MATCH_MODE = 0
) (
  input  logic                 CLK,
  input  logic                 RST,
  spike_event_core_if.slave    bus,
  input  logic                 start_i,
  input  logic                 next_tick_i,
  input  logic [TIME_W-1:0]    tick_i,
  input  logic                 rec_valid_i,
  input  logic [$clog2(N)-1:0] rec_addr_i,
  output logic                 rec_ready_o,
  input  logic                 fifo_rd_i,
  output logic [$clog2(N)-1:0] fifo_data_o,
  output logic                 fifo_empty_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 overrun_o
);
  localparam int LANES = BUS_W / TIME_W;
  localparam int WORDS = N / LANES;
  localparam int AW    = $clog2(WORDS);
  localparam int NAW   = $clog2(N);
  localparam int LAW   = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int FAW   = $clog2(FIFO_DEPTH);
  localparam int BPL   = TIME_W / 8;

  typedef enum logic [1:0] {IDLE, READ, EVAL, DONE} state_t;

  state_t            r_state;
  logic [AW-1:0]     r_wordPtr;
  logic [TIME_W-1:0] r_tickQ;
  logic [LANES-1:0]  r_mask;
  logic [N-1:0]      r_fired;
  logic              r_busy;
  logic              r_done;
  logic              r_overrun;
  logic              r_rvalid;
  logic [BUS_W-1:0]  r_rdata;
  logic [BUS_W-1:0]  r_mem [WORDS];
  logic [NAW-1:0]    r_fifoMem [FIFO_DEPTH];
  logic [FAW:0]      r_wrPtr;
  logic [FAW:0]      r_rdPtr;

  logic              w_busAct;
  logic              w_recAct;
  logic              w_scanRd;
  logic [AW-1:0]     w_memAddr;
  logic [BUS_W-1:0]  w_memWdata;
  logic [LANES-1:0]  w_laneWe;
  logic [BUS_W-1:0]  w_rdWord;
  logic [LANES-1:0]  w_match;
  logic [LAW-1:0]    w_lowLane;
  logic [NAW-1:0]    w_pushAddr;
  logic              w_fifoEmpty;
  logic              w_fifoFull;
  logic              w_push;
  logic              w_pop;
  logic              w_unusedAddrBits;

  assign w_busAct = bus.bus_req_i;
  assign w_recAct = rec_valid_i & ~bus.bus_req_i;
  // The scan only gets the port on cycles nobody else wants it.
  assign w_scanRd = (r_state == READ) & ~bus.bus_req_i & ~rec_valid_i;

  assign w_unusedAddrBits = ^{bus.bus_addr_i[31:AW+2], bus.bus_addr_i[1:0]};

  // Single-port arbitration: bus beats record beats scan.
  always_comb begin
    w_memAddr  = r_wordPtr;
    w_memWdata = bus.bus_wdata_i;
    w_laneWe   = '0;
    if (w_busAct) begin
      w_memAddr = bus.bus_addr_i[AW+1:2];
      for (int k = 0; k < LANES; k++)
        w_laneWe[k] = bus.bus_we_i & (&bus.bus_be_i[k*BPL +: BPL]);
    end else if (w_recAct) begin
      w_memAddr  = AW'(rec_addr_i / NAW'(LANES));
      w_memWdata = {LANES{tick_i}};
      for (int k = 0; k < LANES; k++)
        w_laneWe[k] = (NAW'(k) == NAW'(rec_addr_i % NAW'(LANES)));
    end
  end

  assign w_rdWord = r_mem[w_memAddr];

  // Per-lane firing rule; the all-ones time is a "never fire" sentinel.
  always_comb begin
    w_match = '0;
    for (int k = 0; k < LANES; k++) begin
      if (w_rdWord[k*TIME_W +: TIME_W] != {TIME_W{1'b1}}) begin
        if (MATCH_MODE == 0)
          w_match[k] = (w_rdWord[k*TIME_W +: TIME_W] == r_tickQ);
        else
          w_match[k] = (w_rdWord[k*TIME_W +: TIME_W] <= r_tickQ) &
                       ~r_fired[NAW'(r_wordPtr * LANES + k)];
      end
    end
  end

  // Lowest pending lane so addresses leave in ascending order.
  always_comb begin
    w_lowLane = '0;
    for (int k = LANES - 1; k >= 0; k--)
      if (r_mask[k]) w_lowLane = LAW'(k);
  end

  assign w_pushAddr  = NAW'(r_wordPtr * LANES) + NAW'(w_lowLane);
  assign w_fifoEmpty = (r_wrPtr == r_rdPtr);
  assign w_fifoFull  = (r_wrPtr[FAW] != r_rdPtr[FAW]) &&
                       (r_wrPtr[FAW-1:0] == r_rdPtr[FAW-1:0]);
  assign w_push      = (r_state == EVAL) && (|r_mask) && !w_fifoFull;
  assign w_pop       = fifo_rd_i && !w_fifoEmpty;

  // Storage arrays carry no reset: memory contents survive RST.
  always_ff @(posedge CLK) begin
    for (int k = 0; k < LANES; k++)
      if (w_laneWe[k])
        r_mem[w_memAddr][k*TIME_W +: TIME_W] <= w_memWdata[k*TIME_W +: TIME_W];
    if (w_push)
      r_fifoMem[r_wrPtr[FAW-1:0]] <= w_pushAddr;
  end

  // Scan FSM, FIFO pointers, bus response and status flags.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= IDLE;
      r_wordPtr <= '0;
      r_tickQ   <= '0;
      r_mask    <= '0;
      r_fired   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_wrPtr   <= '0;
      r_rdPtr   <= '0;
    end else begin
      r_rvalid <= bus.bus_req_i;
      r_rdata  <= (bus.bus_req_i & ~bus.bus_we_i) ? w_rdWord : '0;
      r_done   <= 1'b0;
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      if ((r_state != IDLE) && (start_i || next_tick_i))
        r_overrun <= 1'b1;
      case (r_state)
        IDLE: begin
          if (start_i || next_tick_i) begin
            r_tickQ   <= tick_i;
            r_wordPtr <= '0;
            r_busy    <= 1'b1;
            r_state   <= READ;
            if (start_i) begin
              r_fired   <= '0;
              r_overrun <= 1'b0;
            end
          end
        end
        READ: begin
          if (w_scanRd) begin
            r_mask  <= w_match;
            r_state <= EVAL;
          end
        end
        EVAL: begin
          if (|r_mask) begin
            if (!w_fifoFull) begin
              r_mask[w_lowLane] <= 1'b0;
              if (MATCH_MODE == 1) r_fired[w_pushAddr] <= 1'b1;
            end
          end else if (r_wordPtr == AW'(WORDS - 1)) begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_wordPtr <= r_wordPtr + 1'b1;
            r_state   <= READ;
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.bus_gnt_o    = bus.bus_req_i;
  assign bus.bus_rvalid_o = r_rvalid;
  assign bus.bus_rdata_o  = r_rdata;
  assign rec_ready_o      = w_recAct;
  assign fifo_empty_o     = w_fifoEmpty;
  assign fifo_data_o      = w_fifoEmpty ? '0 : r_fifoMem[r_rdPtr[FAW-1:0]];
  assign busy_o           = r_busy;
  assign done_o           = r_done;
  assign overrun_o        = r_overrun;
endmodule
